// File: rtl/junction_pkg.sv
// junction_pkg: shared types and default timing for the junction controller.
//   state_t : FSM state encoding of the junction sequencer
//   lamp_t  : one approach's red/orange/green lamp set
//   DEF_*   : default phase durations in clock cycles and counter width
package junction_pkg;

  typedef enum logic [2:0] {
    AR_TO_NS  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_ORANGE = 3'd2,
    AR_TO_EW  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_ORANGE = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam int DEF_GREEN_CYCLES   = 8;
  localparam int DEF_ORANGE_CYCLES  = 2;
  localparam int DEF_ALL_RED_CYCLES = 1;
  localparam int DEF_WALK_CYCLES    = 4;
  localparam int DEF_CNT_W          = 4;

  typedef struct packed {
    logic red;
    logic orange;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_ORANGE = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  // True when an approach shows anything other than plain red.
  function automatic logic lamp_is_go(input lamp_t l);
    return l.orange | l.green | ~l.red;
  endfunction

endpackage

// File: rtl/junction_controller_phase_timer.sv
// phase_timer: phase duration counter for the junction sequencer.
//   clk    : system clock, rising edge
//   srst   : synchronous active-high reset, clears the count
//   i_clr  : clear the count on this edge (phase entry)
//   i_dur  : duration of the current phase in cycles (>=1)
//   o_cnt  : current count within the phase
//   o_done : high in the last cycle of the phase (count == dur-1)
module phase_timer
  import junction_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_clr,
  input  logic [CNT_W:0]   i_dur,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  // The duration is one bit wider than the count so a duration of
  // 2**CNT_W (count reaching all-ones) is still representable.
  localparam logic [CNT_W:0]   DUR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_last;

  assign w_last = i_dur - DUR_ONE;
  assign o_done = ({1'b0, r_cnt} == w_last);
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (srst || i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/junction_controller.sv
// junction_controller: two-approach (NS/EW) junction sequencer with an
// all-red clearance between hand-overs and a latched pedestrian WALK phase.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   ped_req     : pedestrian button, pulse or level, sampled every edge
//   ns_red/ns_orange/ns_green : NS lamp set
//   ew_red/ew_orange/ew_green : EW lamp set
//   walk        : pedestrian WALK lamp
//   ped_pending : a pedestrian request is latched and not yet served
// All lamp outputs are decoded from the state register only.
module junction_controller
  import junction_pkg::*;
#(
  parameter int GREEN_CYCLES   = DEF_GREEN_CYCLES,
  parameter int ORANGE_CYCLES  = DEF_ORANGE_CYCLES,
  parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES,
  parameter int WALK_CYCLES    = DEF_WALK_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_orange,
  output logic ns_green,
  output logic ew_red,
  output logic ew_orange,
  output logic ew_green,
  output logic walk,
  output logic ped_pending
);

  localparam logic [CNT_W:0] DUR_GREEN   = (CNT_W+1)'(GREEN_CYCLES);
  localparam logic [CNT_W:0] DUR_ORANGE  = (CNT_W+1)'(ORANGE_CYCLES);
  localparam logic [CNT_W:0] DUR_ALL_RED = (CNT_W+1)'(ALL_RED_CYCLES);
  localparam logic [CNT_W:0] DUR_WALK    = (CNT_W+1)'(WALK_CYCLES);
  localparam logic [CNT_W:0] DUR_ONE     = 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ped_pending;
  logic             r_next_dir;     // 0: NS goes next after WALK, 1: EW
  logic             w_next_dir_next;
  logic [CNT_W:0]   w_dur;
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;
  logic             w_enter_walk;
  lamp_t            w_ns_lamp;
  lamp_t            w_ew_lamp;
  logic             w_walk;

  // Duration of the phase currently being timed.
  always_comb begin
    w_dur = DUR_ALL_RED;
    case (r_state)
      NS_GREEN, EW_GREEN:   w_dur = DUR_GREEN;
      NS_ORANGE, EW_ORANGE: w_dur = DUR_ORANGE;
      PED_WALK:             w_dur = DUR_WALK;
      default:              w_dur = DUR_ALL_RED;
    endcase
  end

  // Every state leaves on its done cycle, so clearing on done is the
  // same as clearing on every state entry.
  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk    (clk),
    .srst   (reset),
    .i_clr  (w_done),
    .i_dur  (w_dur),
    .o_cnt  (w_cnt),
    .o_done (w_done)
  );

  always_comb begin
    w_state_next    = r_state;
    w_next_dir_next = r_next_dir;
    w_enter_walk    = 1'b0;
    if (w_done) begin
      case (r_state)
        NS_GREEN:  w_state_next = NS_ORANGE;
        NS_ORANGE: w_state_next = AR_TO_EW;
        EW_GREEN:  w_state_next = EW_ORANGE;
        EW_ORANGE: w_state_next = AR_TO_NS;
        AR_TO_EW: begin
          w_next_dir_next = 1'b1;
          w_enter_walk    = r_ped_pending;
          w_state_next    = r_ped_pending ? PED_WALK : EW_GREEN;
        end
        AR_TO_NS: begin
          w_next_dir_next = 1'b0;
          w_enter_walk    = r_ped_pending;
          w_state_next    = r_ped_pending ? PED_WALK : NS_GREEN;
        end
        PED_WALK:  w_state_next = r_next_dir ? EW_GREEN : NS_GREEN;
        default:   w_state_next = AR_TO_NS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= AR_TO_NS;
      r_next_dir    <= 1'b0;
      r_ped_pending <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_next_dir <= w_next_dir_next;
      // A press on the WALK entry edge takes priority over the clear,
      // so it is served at the following all-red.
      if (ped_req) begin
        r_ped_pending <= 1'b1;
      end else if (w_enter_walk) begin
        r_ped_pending <= 1'b0;
      end
    end
  end

  // Moore output decode.
  always_comb begin
    w_ns_lamp = LAMP_RED;
    w_ew_lamp = LAMP_RED;
    w_walk    = 1'b0;
    case (r_state)
      NS_GREEN:  w_ns_lamp = LAMP_GREEN;
      NS_ORANGE: w_ns_lamp = LAMP_ORANGE;
      EW_GREEN:  w_ew_lamp = LAMP_GREEN;
      EW_ORANGE: w_ew_lamp = LAMP_ORANGE;
      PED_WALK:  w_walk    = 1'b1;
      default:   ;
    endcase
  end

  assign ns_red      = w_ns_lamp.red;
  assign ns_orange   = w_ns_lamp.orange;
  assign ns_green    = w_ns_lamp.green;
  assign ew_red      = w_ew_lamp.red;
  assign ew_orange   = w_ew_lamp.orange;
  assign ew_green    = w_ew_lamp.green;
  assign walk        = w_walk;
  assign ped_pending = r_ped_pending;

  // Safety checks; ignored by synthesis.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(lamp_is_go(w_ns_lamp) && lamp_is_go(w_ew_lamp)))
        else $error("both approaches non-red");
      assert (!w_walk || (!lamp_is_go(w_ns_lamp) && !lamp_is_go(w_ew_lamp)))
        else $error("walk while an approach is non-red");
      assert ({1'b0, w_cnt} <= (w_dur - DUR_ONE))
        else $error("phase counter beyond duration");
    end
  end

endmodule

// File: tb/tb_junction_controller.sv
// tb_junction_controller: directed self-checking bench for junction_controller.
// Lamp state is compared as a packed pattern
// {ns_red, ns_orange, ns_green, ew_red, ew_orange, ew_green, walk}.
module tb_junction_controller;

  localparam logic [6:0] P_AR   = 7'b100_100_0;
  localparam logic [6:0] P_NSG  = 7'b001_100_0;
  localparam logic [6:0] P_NSO  = 7'b010_100_0;
  localparam logic [6:0] P_EWG  = 7'b100_001_0;
  localparam logic [6:0] P_EWO  = 7'b100_010_0;
  localparam logic [6:0] P_WALK = 7'b100_100_1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ped_req = 1'b0;
  logic ns_red, ns_orange, ns_green;
  logic ew_red, ew_orange, ew_green;
  logic walk, ped_pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  junction_controller dut (
    .clk         (clk),
    .reset       (reset),
    .ped_req     (ped_req),
    .ns_red      (ns_red),
    .ns_orange   (ns_orange),
    .ns_green    (ns_green),
    .ew_red      (ew_red),
    .ew_orange   (ew_orange),
    .ew_green    (ew_green),
    .walk        (walk),
    .ped_pending (ped_pending)
  );

  function automatic logic [6:0] pat();
    return {ns_red, ns_orange, ns_green, ew_red, ew_orange, ew_green, walk};
  endfunction

  // One rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ped_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ped_req = 1'b1;  // a press during reset must not latch
    step();
    step();
    n_cmp++;
    if (pat() !== P_AR) begin
      n_err++;
      $display("FAIL reset_lamps: got %b want %b", pat(), P_AR);
    end
    n_cmp++;
    if (ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pending: got %b want 0", ped_pending);
    end
    ped_req = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    logic [6:0] exp;
    do_reset();
    for (int e = 1; e <= 23; e++) begin
      step();
      if (e <= 8)       exp = P_NSG;
      else if (e <= 10) exp = P_NSO;
      else if (e == 11) exp = P_AR;
      else if (e <= 19) exp = P_EWG;
      else if (e <= 21) exp = P_EWO;
      else if (e == 22) exp = P_AR;
      else              exp = P_NSG;
      n_cmp++;
      if (pat() !== exp) begin
        n_err++;
        $display("FAIL free_run edge %0d: got %b want %b", e, pat(), exp);
      end
    end
    $display("test_free_run done");
  endtask

  task automatic test_ped_ns();
    logic [6:0] exp;
    logic       exp_p;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      ped_req = (e == 3);
      step();
      ped_req = 1'b0;
      if (e <= 8)       exp = P_NSG;
      else if (e <= 10) exp = P_NSO;
      else if (e == 11) exp = P_AR;
      else if (e <= 15) exp = P_WALK;
      else              exp = P_EWG;
      exp_p = (e >= 3 && e <= 11);
      n_cmp++;
      if (pat() !== exp) begin
        n_err++;
        $display("FAIL ped_ns_lamps edge %0d: got %b want %b", e, pat(), exp);
      end
      n_cmp++;
      if (ped_pending !== exp_p) begin
        n_err++;
        $display("FAIL ped_ns_pending edge %0d: got %b want %b", e, ped_pending, exp_p);
      end
    end
    $display("test_ped_ns done");
  endtask

  task automatic test_ped_on_walk_entry();
    logic [6:0] exp;
    logic       exp_p;
    do_reset();
    for (int e = 1; e <= 31; e++) begin
      ped_req = (e == 3) || (e == 12);
      step();
      ped_req = 1'b0;
      if (e <= 8)       exp = P_NSG;
      else if (e <= 10) exp = P_NSO;
      else if (e == 11) exp = P_AR;
      else if (e <= 15) exp = P_WALK;
      else if (e <= 23) exp = P_EWG;
      else if (e <= 25) exp = P_EWO;
      else if (e == 26) exp = P_AR;
      else if (e <= 30) exp = P_WALK;
      else              exp = P_NSG;
      exp_p = (e >= 3 && e <= 26);
      n_cmp++;
      if (pat() !== exp) begin
        n_err++;
        $display("FAIL walk_entry_lamps edge %0d: got %b want %b", e, pat(), exp);
      end
      n_cmp++;
      if (ped_pending !== exp_p) begin
        n_err++;
        $display("FAIL walk_entry_pending edge %0d: got %b want %b", e, ped_pending, exp_p);
      end
    end
    $display("test_ped_on_walk_entry done");
  endtask

  task automatic test_mid_reset();
    // Reset during EW_GREEN with a request latched.
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      ped_req = (e == 13);
      step();
      ped_req = 1'b0;
    end
    n_cmp++;
    if (pat() !== P_EWG || ped_pending !== 1'b1) begin
      n_err++;
      $display("FAIL mid_ew_setup: got %b/%b want %b/1", pat(), ped_pending, P_EWG);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (pat() !== P_AR || ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mid_ew_abort: got %b/%b want %b/0", pat(), ped_pending, P_AR);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (pat() !== P_NSG) begin
      n_err++;
      $display("FAIL mid_ew_restart: got %b want %b", pat(), P_NSG);
    end

    // Reset during PED_WALK, with a re-latched request inside WALK.
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      ped_req = (e == 3) || (e == 13);
      step();
      ped_req = 1'b0;
    end
    n_cmp++;
    if (pat() !== P_WALK || ped_pending !== 1'b1) begin
      n_err++;
      $display("FAIL mid_walk_setup: got %b/%b want %b/1", pat(), ped_pending, P_WALK);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (pat() !== P_AR || ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mid_walk_abort: got %b/%b want %b/0", pat(), ped_pending, P_AR);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (pat() !== P_NSG) begin
      n_err++;
      $display("FAIL mid_walk_restart: got %b want %b", pat(), P_NSG);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_soak();
    logic [6:0] prev;
    logic [6:0] cur;
    logic       ns_go, ew_go, bad;
    int         walks;
    int         greens;
    walks  = 0;
    greens = 0;
    do_reset();
    prev = pat();
    for (int c = 0; c < 2000; c++) begin
      ped_req = ($urandom_range(0, 7) == 0);
      step();
      cur   = pat();
      ns_go = ns_orange | ns_green | ~ns_red;
      ew_go = ew_orange | ew_green | ~ew_red;
      bad   = (ns_go && ew_go)
            || (walk && (ns_go || ew_go))
            || ($countones({ns_red, ns_orange, ns_green}) != 1)
            || ($countones({ew_red, ew_orange, ew_green}) != 1)
            || (cur[0] && !prev[0] && prev !== P_AR)
            || (!cur[0] && prev[0] && cur !== P_NSG && cur !== P_EWG);
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL soak cycle %0d: prev %b cur %b", c, prev, cur);
      end
      if (cur[0] && !prev[0]) walks++;
      if (cur == P_NSG || cur == P_EWG) greens++;
      prev = cur;
    end
    ped_req = 1'b0;
    n_cmp++;
    if (walks == 0 || greens < 1000) begin
      n_err++;
      $display("FAIL soak_activity: walks %0d greens %0d want walks>0 greens>=1000", walks, greens);
    end
    $display("test_soak done: %0d walks", walks);
  endtask

  initial begin
    #1;
    test_reset();
    test_free_run();
    test_ped_ns();
    test_ped_on_walk_entry();
    test_mid_reset();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within 500000 ns");
    $fatal(1, "timeout");
  end

endmodule
